multi_proxy_controller: RTL and testbench
=========================================

Name: multi_proxy_controller

Overview:
- Per-column BISR recompute controller; one instance per systolic-array column.
- Assigns up to NUM_PROXIES proxy PEs to faulty rows of that column and sequences each proxy's weight load.
- Enters proxy matmul, and re-arms when new weights are loaded.
- Extends the single-proxy scheme with multi-fault slots, overflow reporting and a reload-driven reset of assignments.

Parameters:
- ROWS, 4, rows in the column.
- COL_IDX, 0, column served by this instance.
- WORD_SIZE, 16, datapath word width.
- NUM_PROXIES, 2, proxy slots (1..ROWS).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous and active-high.
- stw_complete  in  1  pulse; stw_result_mat is valid in this cycle.
- stw_result_mat  in  ROWS  per-row STW result; 1 = PE good.
- matmul_mode  in  1  array is in matmul phase.
- weights_reload  in  1  pulse; new stationary weights are arriving.
- fpe_in_weight  in  WORD_SIZE  weight of row fpe_idx_sel, driven combinationally by the array.
- rcm_left_in  in  NUM_PROXIES*WORD_SIZE  recompute left operand per slot.
- fpe_idx_sel  out  clog2(ROWS)  row being loaded.
- proxy_en  out  ROWS  OR of one-hot rows of all valid slots.
- slot_valid  out  NUM_PROXIES  slot holds an assigned row.
- slot_row  out  NUM_PROXIES*clog2(ROWS)  assigned row per slot.
- fpe_weight  out  NUM_PROXIES*WORD_SIZE  weight sent to each proxy.
- load_proxy  out  NUM_PROXIES  weight-load strobe per slot.
- proxy_matmul  out  1  proxies are computing.
- proxy_settings  out  3  {stat_bit, out_select, op2_select}.
- proxy_left_in  out  NUM_PROXIES*WORD_SIZE  registered rcm_left_in.
- proxy_out_valid  out  NUM_PROXIES  proxy result valid.
- fault_detected  out  1  latched fault mask is non-zero.
- fault_overflow  out  1  more faults than slots.
- busy  out  1  state is SCAN, LOAD1 or LOAD2.

Behaviour:
- Reset: all outputs 0; internal fault_mask and rem_mask 0; slot_ptr 0; state IDLE.
- IDLE:
  - On stw_complete, fault_mask <= rem_mask <= ~stw_result_mat.
  - If the mask is non-zero, go to SCAN and set fault_detected. Otherwise stay in IDLE with fault_detected 0.
- SCAN:
  - fpe_idx_sel <= lowest set bit of rem_mask.
  - slot_row[slot_ptr] <= that row; slot_valid[slot_ptr] <= 1.
  - Go to LOAD1.
- LOAD1:
  - fpe_weight[slot_ptr] <= fpe_in_weight; load_proxy[slot_ptr] <= 1; proxy_settings <= 3'b001.
  - Go to LOAD2.
- LOAD2:
  - Capture fpe_weight again; clear the row in rem_mask; slot_ptr++.
  - If rem_mask is still non-zero and slots remain, go to SCAN. Otherwise go to COMPUTE.
  - If rem_mask is non-zero when slots are exhausted, set fault_overflow. It is sticky until reload or rst.
- COMPUTE:
  - load_proxy <= 0; fpe_weight <= 0; proxy_settings <= 3'b110; proxy_matmul <= matmul_mode.
  - Stays here until weights_reload.
- Latency: for k assigned faults, COMPUTE is entered k*3+1 cycles after the stw_complete edge. fpe_idx_sel is held for the whole SCAN..LOAD2 window of its slot.
- weights_reload:
  - In any state it wins over all other events, including a simultaneous stw_complete.
  - Next cycle: state IDLE; slot_valid, slot_row, fault_mask, fault_overflow, fault_detected, load_proxy, proxy_matmul, proxy_settings and fpe_weight all 0.
- stw_complete outside IDLE is ignored.
- Datapath, every cycle:
  - proxy_left_in[s] <= slot_valid[s] ? rcm_left_in[s] : 0.
  - proxy_out_valid[s] <= slot_valid[s] & proxy_en_matmul & (proxy_left_in[s] != 0).
- Unused slots hold 0 on all per-slot outputs.
- proxy_en is combinational from slot_valid and slot_row.

Optional Feature:
- Macro MPC_FAULT_COUNT_EN.
- With it defined:
  - Adds output fault_count, width clog2(ROWS)+1, equal to the popcount of fault_mask.
  - Registered one cycle after the fault_mask latch.
  - Cleared by rst and weights_reload.
- Without it: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mpc_pkg:
  - State encodings IDLE/SCAN/LOAD1/LOAD2/COMPUTE.
  - Settings constants SETTINGS_LOAD=3'b001, SETTINGS_MATMUL=3'b110, SETTINGS_IDLE=3'b000.
- Sub-module: reuse priority_encoder (INPUT_WIDTH=ROWS) for lowest-set-bit selection on rem_mask. No other sub-modules.

Test Plan:
- No faults: stw_result_mat=4'b1111 with stw_complete -> state stays IDLE; fault_detected=0; proxy_en=0.
- Single fault: stw_result_mat=4'b1011, fpe_in_weight=16'h0042 -> slot0 row 2; fpe_weight[0]=0x0042 with load_proxy[0]=1 for 2 cycles; COMPUTE 4 cycles after the pulse; settings=3'b110.
- Two faults, NUM_PROXIES=2: stw_result_mat=4'b0110 -> slot0 row 0, slot1 row 3; proxy_en=4'b1001; COMPUTE after 7 cycles; fault_overflow=0.
- Overflow: stw_result_mat=4'b0000 with NUM_PROXIES=2 -> rows 0 and 1 assigned; fault_overflow=1; proxy_en=4'b0011.
- Reload mid-load: weights_reload asserted during LOAD1 -> next cycle IDLE and all slot outputs 0; a stw_complete in the same cycle is ignored.
- Datapath: in COMPUTE, slot0 rcm_left_in=0x0005 with matmul_mode=1 -> proxy_left_in[0]=0x0005 next cycle; proxy_out_valid[0]=1 the cycle after that.

Source files
------------

// File: rtl/multi_proxy_controller_pkg.sv
// Shared state encoding and proxy settings constants for multi_proxy_controller.
package mpc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    LOAD1   = 3'd2,
    LOAD2   = 3'd3,
    COMPUTE = 3'd4
  } mpc_state_e;

  localparam logic [2:0] SETTINGS_IDLE   = 3'b000;
  localparam logic [2:0] SETTINGS_LOAD   = 3'b001;
  localparam logic [2:0] SETTINGS_MATMUL = 3'b110;

  function automatic logic is_busy(input mpc_state_e st);
    return (st == SCAN) || (st == LOAD1) || (st == LOAD2);
  endfunction

endpackage

// File: rtl/multi_proxy_controller_priority_encoder.sv
// Lowest-set-bit priority encoder; valid is high when any input bit is set.
module priority_encoder #(
  parameter  int INPUT_WIDTH = 4,
  localparam int IW = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1
) (
  input  logic [INPUT_WIDTH-1:0] in_vec,
  output logic [IW-1:0]          idx,
  output logic                   valid
);

  // Scan from the top so the lowest set bit is the last one to win
  always_comb begin
    idx   = '0;
    valid = |in_vec;
    for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
      idx = in_vec[i] ? IW'(i) : idx;
    end
  end

endmodule

// File: rtl/multi_proxy_controller.sv
// Per-column BISR controller: maps faulty rows onto proxy slots and sequences their weight loads.
// Optional fault_count output is enabled by defining MPC_FAULT_COUNT_EN.
module multi_proxy_controller
  import mpc_pkg::*;
#(
  parameter  int ROWS        = 4,
  parameter  int COL_IDX     = 0,
  parameter  int WORD_SIZE   = 16,
  parameter  int NUM_PROXIES = 2,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int PW = (NUM_PROXIES > 1) ? $clog2(NUM_PROXIES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stw_complete,
  input  logic [ROWS-1:0]                stw_result_mat,
  input  logic                           matmul_mode,
  input  logic                           weights_reload,
  input  logic [WORD_SIZE-1:0]           fpe_in_weight,
  input  logic [NUM_PROXIES*WORD_SIZE-1:0] rcm_left_in,
  output logic [RW-1:0]                  fpe_idx_sel,
  output logic [ROWS-1:0]                proxy_en,
  output logic [NUM_PROXIES-1:0]         slot_valid,
  output logic [NUM_PROXIES*RW-1:0]      slot_row,
  output logic [NUM_PROXIES*WORD_SIZE-1:0] fpe_weight,
  output logic [NUM_PROXIES-1:0]         load_proxy,
  output logic                           proxy_matmul,
  output logic [2:0]                     proxy_settings,
  output logic [NUM_PROXIES*WORD_SIZE-1:0] proxy_left_in,
  output logic [NUM_PROXIES-1:0]         proxy_out_valid,
  output logic                           fault_detected,
  output logic                           fault_overflow,
  output logic                           busy
`ifdef MPC_FAULT_COUNT_EN
  ,
  output logic [RW:0]                    fault_count
`endif
);

  localparam logic [PW-1:0] LAST_SLOT = PW'(NUM_PROXIES - 1);

  if (NUM_PROXIES < 1 || NUM_PROXIES > ROWS || COL_IDX < 0) begin : g_bad_params
    $error("multi_proxy_controller: NUM_PROXIES must be 1..ROWS and COL_IDX non-negative");
  end

  mpc_state_e                     state_r, state_nxt_s;
  logic [ROWS-1:0]                fault_mask_r, fault_mask_nxt_s;
  logic [ROWS-1:0]                rem_mask_r, rem_mask_nxt_s;
  logic [PW-1:0]                  slot_ptr_r, slot_ptr_nxt_s;
  logic [RW-1:0]                  fpe_idx_sel_r, fpe_idx_sel_nxt_s;
  logic [NUM_PROXIES-1:0]         slot_valid_r, slot_valid_nxt_s;
  logic [NUM_PROXIES*RW-1:0]      slot_row_r, slot_row_nxt_s;
  logic [NUM_PROXIES*WORD_SIZE-1:0] fpe_weight_r, fpe_weight_nxt_s;
  logic [NUM_PROXIES-1:0]         load_proxy_r, load_proxy_nxt_s;
  logic                           proxy_matmul_r, proxy_matmul_nxt_s;
  logic [2:0]                     proxy_settings_r, proxy_settings_nxt_s;
  logic                           fault_detected_r, fault_detected_nxt_s;
  logic                           fault_overflow_r, fault_overflow_nxt_s;
  logic [NUM_PROXIES*WORD_SIZE-1:0] proxy_left_in_r;
  logic [NUM_PROXIES-1:0]         proxy_out_valid_r;

  logic [RW-1:0]   pe_idx_s;
  logic            pe_valid_s;
  logic [ROWS-1:0] stw_fault_s;
  logic [ROWS-1:0] row_bit_s;
  logic [ROWS-1:0] rem_left_s;
  logic [ROWS-1:0] proxy_en_s;

  priority_encoder #(.INPUT_WIDTH(ROWS)) u_lowest_fault (
    .in_vec (rem_mask_r),
    .idx    (pe_idx_s),
    .valid  (pe_valid_s)
  );

  assign stw_fault_s = ~stw_result_mat;
  assign row_bit_s   = ROWS'(1) << fpe_idx_sel_r;
  assign rem_left_s  = rem_mask_r & ~row_bit_s;

  // Next-state and next-register values; weights_reload overrides every other event
  always_comb begin
    state_nxt_s          = state_r;
    fault_mask_nxt_s     = fault_mask_r;
    rem_mask_nxt_s       = rem_mask_r;
    slot_ptr_nxt_s       = slot_ptr_r;
    fpe_idx_sel_nxt_s    = fpe_idx_sel_r;
    slot_valid_nxt_s     = slot_valid_r;
    slot_row_nxt_s       = slot_row_r;
    fpe_weight_nxt_s     = fpe_weight_r;
    load_proxy_nxt_s     = load_proxy_r;
    proxy_matmul_nxt_s   = proxy_matmul_r;
    proxy_settings_nxt_s = proxy_settings_r;
    fault_detected_nxt_s = |fault_mask_r;
    fault_overflow_nxt_s = fault_overflow_r;
    if (weights_reload) begin
      state_nxt_s          = IDLE;
      fault_mask_nxt_s     = '0;
      rem_mask_nxt_s       = '0;
      slot_ptr_nxt_s       = '0;
      fpe_idx_sel_nxt_s    = '0;
      slot_valid_nxt_s     = '0;
      slot_row_nxt_s       = '0;
      fpe_weight_nxt_s     = '0;
      load_proxy_nxt_s     = '0;
      proxy_matmul_nxt_s   = 1'b0;
      proxy_settings_nxt_s = SETTINGS_IDLE;
      fault_detected_nxt_s = 1'b0;
      fault_overflow_nxt_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (stw_complete) begin
            fault_mask_nxt_s     = stw_fault_s;
            rem_mask_nxt_s       = stw_fault_s;
            slot_ptr_nxt_s       = '0;
            fault_detected_nxt_s = |stw_fault_s;
            state_nxt_s          = (|stw_fault_s) ? SCAN : IDLE;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        SCAN: begin
          if (pe_valid_s) begin
            fpe_idx_sel_nxt_s                    = pe_idx_s;
            slot_row_nxt_s[slot_ptr_r*RW +: RW]  = pe_idx_s;
            slot_valid_nxt_s[slot_ptr_r]         = 1'b1;
            load_proxy_nxt_s                     = '0;
            state_nxt_s                          = LOAD1;
          end else begin
            state_nxt_s = COMPUTE;
          end
        end
        LOAD1: begin
          fpe_weight_nxt_s[slot_ptr_r*WORD_SIZE +: WORD_SIZE] = fpe_in_weight;
          load_proxy_nxt_s[slot_ptr_r]                        = 1'b1;
          proxy_settings_nxt_s                                = SETTINGS_LOAD;
          state_nxt_s                                         = LOAD2;
        end
        LOAD2: begin
          fpe_weight_nxt_s[slot_ptr_r*WORD_SIZE +: WORD_SIZE] = fpe_in_weight;
          rem_mask_nxt_s                                      = rem_left_s;
          if (!(|rem_left_s)) begin
            state_nxt_s = COMPUTE;
          end else if (slot_ptr_r != LAST_SLOT) begin
            slot_ptr_nxt_s = slot_ptr_r + PW'(1);
            state_nxt_s    = SCAN;
          end else begin
            fault_overflow_nxt_s = 1'b1;
            state_nxt_s          = COMPUTE;
          end
        end
        COMPUTE: begin
          load_proxy_nxt_s     = '0;
          fpe_weight_nxt_s     = '0;
          proxy_settings_nxt_s = SETTINGS_MATMUL;
          proxy_matmul_nxt_s   = matmul_mode;
          state_nxt_s          = COMPUTE;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Control and per-slot register state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      fault_mask_r     <= '0;
      rem_mask_r       <= '0;
      slot_ptr_r       <= '0;
      fpe_idx_sel_r    <= '0;
      slot_valid_r     <= '0;
      slot_row_r       <= '0;
      fpe_weight_r     <= '0;
      load_proxy_r     <= '0;
      proxy_matmul_r   <= 1'b0;
      proxy_settings_r <= SETTINGS_IDLE;
      fault_detected_r <= 1'b0;
      fault_overflow_r <= 1'b0;
    end else begin
      state_r          <= state_nxt_s;
      fault_mask_r     <= fault_mask_nxt_s;
      rem_mask_r       <= rem_mask_nxt_s;
      slot_ptr_r       <= slot_ptr_nxt_s;
      fpe_idx_sel_r    <= fpe_idx_sel_nxt_s;
      slot_valid_r     <= slot_valid_nxt_s;
      slot_row_r       <= slot_row_nxt_s;
      fpe_weight_r     <= fpe_weight_nxt_s;
      load_proxy_r     <= load_proxy_nxt_s;
      proxy_matmul_r   <= proxy_matmul_nxt_s;
      proxy_settings_r <= proxy_settings_nxt_s;
      fault_detected_r <= fault_detected_nxt_s;
      fault_overflow_r <= fault_overflow_nxt_s;
    end
  end

  // Recompute operand staging; a result is valid only for a live slot with a non-zero operand
  always_ff @(posedge clk) begin
    if (rst) begin
      proxy_left_in_r   <= '0;
      proxy_out_valid_r <= '0;
    end else begin
      for (int s = 0; s < NUM_PROXIES; s++) begin
        proxy_left_in_r[s*WORD_SIZE +: WORD_SIZE] <=
          slot_valid_r[s] ? rcm_left_in[s*WORD_SIZE +: WORD_SIZE] : '0;
        proxy_out_valid_r[s] <= slot_valid_r[s] & proxy_matmul_r &
                                (proxy_left_in_r[s*WORD_SIZE +: WORD_SIZE] != '0);
      end
    end
  end

  // Row enables are the union of the one-hot rows of all live slots
  always_comb begin
    proxy_en_s = '0;
    for (int s = 0; s < NUM_PROXIES; s++) begin
      proxy_en_s = proxy_en_s |
                   ({ROWS{slot_valid_r[s]}} & (ROWS'(1) << slot_row_r[s*RW +: RW]));
    end
  end

`ifdef MPC_FAULT_COUNT_EN
  logic [RW:0] fault_count_r;
  logic [RW:0] fault_pop_s;

  // Popcount of the latched fault mask
  always_comb begin
    fault_pop_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      fault_pop_s = fault_pop_s + (RW+1)'(fault_mask_r[r]);
    end
  end

  // Fault count lags the mask latch by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_count_r <= '0;
    end else if (weights_reload) begin
      fault_count_r <= '0;
    end else begin
      fault_count_r <= fault_pop_s;
    end
  end

  assign fault_count = fault_count_r;
`endif

  assign fpe_idx_sel     = fpe_idx_sel_r;
  assign proxy_en        = proxy_en_s;
  assign slot_valid      = slot_valid_r;
  assign slot_row        = slot_row_r;
  assign fpe_weight      = fpe_weight_r;
  assign load_proxy      = load_proxy_r;
  assign proxy_matmul    = proxy_matmul_r;
  assign proxy_settings  = proxy_settings_r;
  assign proxy_left_in   = proxy_left_in_r;
  assign proxy_out_valid = proxy_out_valid_r;
  assign fault_detected  = fault_detected_r;
  assign fault_overflow  = fault_overflow_r;
  assign busy            = is_busy(state_r);

endmodule

// File: tb/tb_multi_proxy_controller.sv
// Self-checking bench for multi_proxy_controller (ROWS=4, NUM_PROXIES=2, WORD_SIZE=16).
module tb_multi_proxy_controller;

  localparam logic [2:0] SET_LOAD   = 3'b001;
  localparam logic [2:0] SET_MATMUL = 3'b110;

  logic        clk;
  logic        rst;
  logic        stw_complete;
  logic [3:0]  stw_result_mat;
  logic        matmul_mode;
  logic        weights_reload;
  logic [15:0] fpe_in_weight;
  logic [31:0] rcm_left_in;
  logic [1:0]  fpe_idx_sel;
  logic [3:0]  proxy_en;
  logic [1:0]  slot_valid;
  logic [3:0]  slot_row;
  logic [31:0] fpe_weight;
  logic [1:0]  load_proxy;
  logic        proxy_matmul;
  logic [2:0]  proxy_settings;
  logic [31:0] proxy_left_in;
  logic [1:0]  proxy_out_valid;
  logic        fault_detected;
  logic        fault_overflow;
  logic        busy;
`ifdef MPC_FAULT_COUNT_EN
  logic [2:0]  fault_count;
`endif

  multi_proxy_controller #(
    .ROWS(4), .COL_IDX(0), .WORD_SIZE(16), .NUM_PROXIES(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stw_complete    (stw_complete),
    .stw_result_mat  (stw_result_mat),
    .matmul_mode     (matmul_mode),
    .weights_reload  (weights_reload),
    .fpe_in_weight   (fpe_in_weight),
    .rcm_left_in     (rcm_left_in),
    .fpe_idx_sel     (fpe_idx_sel),
    .proxy_en        (proxy_en),
    .slot_valid      (slot_valid),
    .slot_row        (slot_row),
    .fpe_weight      (fpe_weight),
    .load_proxy      (load_proxy),
    .proxy_matmul    (proxy_matmul),
    .proxy_settings  (proxy_settings),
    .proxy_left_in   (proxy_left_in),
    .proxy_out_valid (proxy_out_valid),
    .fault_detected  (fault_detected),
    .fault_overflow  (fault_overflow),
    .busy            (busy)
`ifdef MPC_FAULT_COUNT_EN
    ,
    .fault_count     (fault_count)
`endif
  );

  // Array model: row r holds weight 0x0040 + r
  assign fpe_in_weight = 16'h0040 + {14'd0, fpe_idx_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  typedef struct {
    int         slot;
    logic [1:0] row;
    logic [15:0] weight;
  } load_exp_t;

  load_exp_t sb_q[$];

  typedef struct {
    logic [3:0] stw;
    int         k;
    logic [3:0] en;
    logic [1:0] valid;
    logic [1:0] row0;
    logic [1:0] row1;
    logic       ovf;
    logic       det;
  } vec_t;

  vec_t vecs[5];

  // Expected loads: faulty rows in ascending order, at most one per slot
  task automatic push_expected(input logic [3:0] stw);
    int s = 0;
    for (int r = 0; r < 4; r++) begin
      if (!stw[r] && s < 2) begin
        sb_q.push_back('{s, 2'(r), 16'h0040 + 16'(r)});
        s++;
      end
    end
  endtask

  function automatic int popcount4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  // Load-strobe monitor: pops the scoreboard on each rising strobe and checks strobe length
  bit        mon_en = 1'b1;
  logic [1:0] lp_prev = 2'b00;
  int        lp_len [2];
  always @(negedge clk) begin
    load_exp_t e;
    if (mon_en && !rst) begin
      for (int s = 0; s < 2; s++) begin
        if (load_proxy[s] && !lp_prev[s]) begin
          if (sb_q.size() == 0) begin
            total_cnt++;
            $display("FAIL sb_unexpected_load: slot %0d strobed with no expected entry", s);
          end else begin
            e = sb_q.pop_front();
            check("sb_slot", 64'(s), 64'(e.slot));
            check("sb_idx_sel", fpe_idx_sel, e.row);
            check("sb_weight", fpe_weight[s*16 +: 16], e.weight);
            check("sb_slot_row", slot_row[s*2 +: 2], e.row);
            check("sb_settings", proxy_settings, SET_LOAD);
          end
          lp_len[s] <= 1;
        end else if (load_proxy[s]) begin
          lp_len[s] <= lp_len[s] + 1;
        end else if (lp_prev[s]) begin
          check("load_len", 64'(lp_len[s]), 64'd2);
        end
      end
    end
    lp_prev <= load_proxy;
  end

  task automatic pulse_reload();
    @(negedge clk);
    weights_reload = 1'b1;
    @(negedge clk);
    weights_reload = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    bit seen;
    @(negedge clk);
    stw_result_mat = v.stw;
    stw_complete   = 1'b1;
    push_expected(v.stw);
    @(negedge clk);
    stw_complete   = 1'b0;
    stw_result_mat = 4'b1111;
    if (v.k == 0) begin
      repeat (6) @(negedge clk);
      check("nofault_busy", busy, 1'b0);
      check("nofault_settings", proxy_settings, 3'b000);
    end else begin
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
        @(negedge clk);
        n++;
        if (proxy_settings == SET_MATMUL) seen = 1'b1;
      end
      check("compute_latency", 64'(n), 64'(3 * v.k + 1));
      check("compute_weight_zero", fpe_weight, 32'h0);
      check("compute_load_zero", load_proxy, 2'b00);
      check("compute_busy", busy, 1'b0);
    end
    check("proxy_en", proxy_en, v.en);
    check("slot_valid", slot_valid, v.valid);
    check("slot_row0", slot_row[1:0], v.row0);
    check("slot_row1", slot_row[3:2], v.row1);
    check("fault_overflow", fault_overflow, v.ovf);
    check("fault_detected", fault_detected, v.det);
`ifdef MPC_FAULT_COUNT_EN
    check("fault_count", fault_count, 3'(popcount4(~v.stw)));
`endif
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    pulse_reload();
    check("reload_slot_valid", slot_valid, 2'b00);
    check("reload_proxy_en", proxy_en, 4'b0000);
    check("reload_flags", {fault_overflow, fault_detected, proxy_matmul, busy}, 4'b0000);
    check("reload_settings", proxy_settings, 3'b000);
  endtask

  int n;

  initial begin
    rst            = 1'b1;
    stw_complete   = 1'b0;
    stw_result_mat = 4'b1111;
    matmul_mode    = 1'b1;
    weights_reload = 1'b0;
    rcm_left_in    = 32'h0;

    vecs[0] = '{4'b1111, 0, 4'b0000, 2'b00, 2'd0, 2'd0, 1'b0, 1'b0};
    vecs[1] = '{4'b1011, 1, 4'b0100, 2'b01, 2'd2, 2'd0, 1'b0, 1'b1};
    vecs[2] = '{4'b0110, 2, 4'b1001, 2'b11, 2'd0, 2'd3, 1'b0, 1'b1};
    vecs[3] = '{4'b0000, 2, 4'b0011, 2'b11, 2'd0, 2'd1, 1'b1, 1'b1};
    vecs[4] = '{4'b0111, 1, 4'b1000, 2'b01, 2'd3, 2'd0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, fault_detected, fault_overflow, proxy_matmul}, 4'b0000);
    check("rst_slots", {slot_valid, slot_row, load_proxy}, 8'h00);
    check("rst_settings", proxy_settings, 3'b000);
    check("rst_weight", fpe_weight, 32'h0);
    check("rst_dp", {proxy_left_in, proxy_out_valid, proxy_en, fpe_idx_sel}, 40'h0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
    end

    // Datapath: single fault on row 2, then drive recompute operands in COMPUTE
    @(negedge clk);
    stw_result_mat = 4'b1011;
    stw_complete   = 1'b1;
    push_expected(4'b1011);
    @(negedge clk);
    stw_complete   = 1'b0;
    stw_result_mat = 4'b1111;
    n = 0;
    while (proxy_settings != SET_MATMUL && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("dp_reach_compute", proxy_settings, SET_MATMUL);
    @(negedge clk);
    check("dp_matmul", proxy_matmul, 1'b1);
    rcm_left_in = {16'h0007, 16'h0005};
    @(negedge clk);
    check("dp_left0", proxy_left_in[15:0], 16'h0005);
    check("dp_left1_unused", proxy_left_in[31:16], 16'h0000);
    check("dp_valid_early", proxy_out_valid, 2'b00);
    @(negedge clk);
    check("dp_valid0", proxy_out_valid, 2'b01);
    rcm_left_in = 32'h0;
    check("dp_sb_drain", 64'(sb_q.size()), 64'd0);
    pulse_reload();
    @(negedge clk);
    check("dp_left_cleared", proxy_left_in, 32'h0);

    // Reload during LOAD1 with a simultaneous stw_complete
    mon_en = 1'b0;
    @(negedge clk);
    stw_result_mat = 4'b1011;
    stw_complete   = 1'b1;
    @(negedge clk);
    stw_complete   = 1'b0;
    stw_result_mat = 4'b1111;
    @(negedge clk);
    check("mid_in_load1", busy, 1'b1);
    weights_reload = 1'b1;
    stw_complete   = 1'b1;
    stw_result_mat = 4'b0000;
    @(negedge clk);
    weights_reload = 1'b0;
    stw_complete   = 1'b0;
    stw_result_mat = 4'b1111;
    check("mid_idle", busy, 1'b0);
    check("mid_slots", {slot_valid, slot_row, load_proxy}, 8'h00);
    check("mid_settings", proxy_settings, 3'b000);
    check("mid_weight", fpe_weight, 32'h0);
    check("mid_flags", {fault_detected, fault_overflow, proxy_matmul}, 3'b000);
    repeat (4) @(negedge clk);
    check("mid_stw_ignored", {busy, fault_detected, slot_valid}, 4'b0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
